// File: rtl/sipo_word_assembler_if.sv
// Handshake bundle for sipo_word_assembler: serial input side, parallel
// output side and the synchronous flush. The slave modport is the assembler,
// the master modport is whatever feeds bits and consumes words.
interface sipo_word_assembler_if #(
  parameter int WIDTH = 3
);
  localparam int CW = $clog2(WIDTH + 2);

  logic             clear;
  logic             sin;
  logic             sin_valid;
  logic             sin_ready;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             pout_perr;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output clear, sin, sin_valid, pout_ready,
    input  sin_ready, pout, pout_valid, pout_perr, bit_cnt
  );

  modport slave (
    input  clear, sin, sin_valid, pout_ready,
    output sin_ready, pout, pout_valid, pout_perr, bit_cnt
  );
endinterface

// File: rtl/sipo_word_assembler.sv
// Serial-to-parallel word assembler with one shift register and one output
// holding register, so the next word can be collected while the previous one
// waits for the consumer.
// Optional feature macro: PARITY_CHECK_EN -- each word carries a trailing
// even-parity bit that is checked and reported on pout_perr.
//
// state      | meaning
// COLLECT    | shifting serial bits in, sin_ready=1
// HOLD       | complete word parked in sr, output slot busy, sin_ready=0
module sipo_word_assembler #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  sipo_word_assembler_if.slave bus
);
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int CW    = $clog2(WIDTH + 2);
  localparam int NBITS = WIDTH + (PAR_EN ? 1 : 0);

  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
  localparam logic [CW-1:0] CNT_DATA = CW'(WIDTH);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvalid_q, pvalid_d;
  logic             perr_q, perr_d;
  logic             par_q, par_d;

  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word_done;
  logic             perr_done;
  logic             rdy;
  logic             accept;
  logic             drain;
  logic             complete;

  // Handshake decode and the word that finishes on this edge.
  always_comb begin
    sr_shift  = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.sin} : {bus.sin, sr_q[WIDTH-1:1]};
    rdy       = (state_q == ST_COLLECT);
    accept    = bus.sin_valid && rdy;
    drain     = pvalid_q && bus.pout_ready;
    complete  = accept && (cnt_q == CNT_LAST);
    // With parity the last bit is the parity bit, so sr already holds the data.
    word_done = PAR_EN ? sr_q : sr_shift;
    perr_done = PAR_EN & (par_q ^ bus.sin);
  end

  // Next-state logic for collection, parking in HOLD and output handoff.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    perr_d   = perr_q;
    par_d    = par_q;
    if (state_q == ST_COLLECT) begin
      if (drain) pvalid_d = 1'b0;
      if (complete) begin
        if (!pvalid_q || bus.pout_ready) begin
          pout_d   = word_done;
          pvalid_d = 1'b1;
          perr_d   = perr_done;
          cnt_d    = '0;
          sr_d     = '0;
          par_d    = 1'b0;
        end else begin
          sr_d    = word_done;
          par_d   = par_q ^ bus.sin;
          cnt_d   = CNT_FULL;
          state_d = ST_HOLD;
        end
      end else if (accept) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q < CNT_DATA) sr_d = sr_shift;
        par_d = par_q ^ bus.sin;
      end
    end else begin
      // pout_valid is always set in HOLD, so it simply stays high on handoff.
      if (drain) begin
        pout_d  = sr_q;
        perr_d  = PAR_EN & par_q;
        cnt_d   = '0;
        sr_d    = '0;
        par_d   = 1'b0;
        state_d = ST_COLLECT;
      end
    end
  end

  // State registers; reset and clear both flush to an empty COLLECT state.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear) begin
      state_q  <= ST_COLLECT;
      sr_q     <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      pvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      perr_q   <= perr_d;
      par_q    <= par_d;
    end
  end

  assign bus.sin_ready  = rdy;
  assign bus.pout       = pout_q;
  assign bus.pout_valid = pvalid_q;
  assign bus.pout_perr  = perr_q;
  assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_sipo_word_assembler.sv
// Bench for sipo_word_assembler: directed scenarios plus a randomized run
// checked against a word-queue model of the assembler.
module tb_sipo_word_assembler;
  localparam int W = 3;
`ifdef PARITY_CHECK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + PAR;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sipo_word_assembler_if #(.WIDTH(W)) bm();
  sipo_word_assembler_if #(.WIDTH(W)) bl();

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .bus(bm.slave)
  );
  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .bus(bl.slave)
  );

  // Model: completed-but-unconsumed words (at most two fit), the partial bits.
  logic [W-1:0] pend_w[$];
  bit           pend_p[$];
  bit           bits[$];
  logic [W-1:0] last_pout = '0;
  bit           last_perr = 1'b0;

  task automatic model_edge();
    bit acc, drn, x;
    logic [W-1:0] w;
    if (rst || bm.clear) begin
      pend_w.delete(); pend_p.delete(); bits.delete();
      last_pout = '0; last_perr = 1'b0;
      return;
    end
    acc = bm.sin_valid && (pend_w.size() < 2);
    drn = (pend_w.size() > 0) && bm.pout_ready;
    if (drn) begin
      last_pout = pend_w.pop_front();
      last_perr = pend_p.pop_front();
    end
    if (acc) begin
      bits.push_back(bm.sin);
      if (bits.size() == NB) begin
        w = '0; x = 1'b0;
        for (int i = 0; i < W; i++) w = {w[W-2:0], bits[i]};
        for (int i = 0; i < NB; i++) x ^= bits[i];
        pend_w.push_back(w);
        pend_p.push_back((PAR != 0) ? x : 1'b0);
        bits.delete();
      end
    end
  endtask

  task automatic cyc(input logic sv, input logic s, input logic pr, input logic clr);
    bm.sin_valid = sv; bm.sin = s; bm.pout_ready = pr; bm.clear = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic pr);
    for (int i = W - 1; i >= 0; i--) cyc(1'b1, w[i], pr, 1'b0);
    if (PAR != 0) cyc(1'b1, ^w, pr, 1'b0);
  endtask

  task automatic lsb_bit(input logic s);
    bl.sin = s; bl.sin_valid = 1'b1; bl.pout_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    bl.sin_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bl.sin_valid = 1'b1; bl.sin = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    bl.sin_valid = 1'b0;
    checks++; if (bm.pout !== 3'b000) begin errors++; $display("FAIL reset_pout got=%b exp=000", bm.pout); end
    checks++; if (bm.pout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bm.pout_valid); end
    checks++; if (bm.bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bm.bit_cnt); end
    checks++; if (bm.sin_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bm.sin_ready); end
    checks++; if (bm.pout_perr !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", bm.pout_perr); end
    checks++; if ({bl.pout, bl.pout_valid, bl.pout_perr, bl.bit_cnt} !== 8'h00) begin
      errors++; $display("FAIL reset_lsb got=%b %b %b %0d exp=000 0 0 0", bl.pout, bl.pout_valid, bl.pout_perr, bl.bit_cnt);
    end
  endtask

  task automatic test_basic();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bm.pout_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", bm.pout_valid); end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    if (PAR != 0) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bm.pout_valid !== 1'b1 || bm.pout !== 3'b101) begin
      errors++; $display("FAIL basic_word got=%b v=%b exp=101 v=1", bm.pout, bm.pout_valid);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bm.pout_valid !== 1'b0 || bm.pout !== 3'b101) begin
      errors++; $display("FAIL basic_one_cycle got=%b v=%b exp=101 v=0", bm.pout, bm.pout_valid);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] streams[2] = '{3'b101, 3'b110};
    logic [W-1:0] expect_w[2] = '{3'b101, 3'b011};
    for (int k = 0; k < 2; k++) begin
      for (int i = W - 1; i >= 0; i--) lsb_bit(streams[k][i]);
      if (PAR != 0) lsb_bit(^streams[k]);
      checks++; if (bl.pout_valid !== 1'b1 || bl.pout !== expect_w[k]) begin
        errors++; $display("FAIL lsb_word%0d got=%b v=%b exp=%b v=1", k, bl.pout, bl.pout_valid, expect_w[k]);
      end
    end
    bl.pout_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    send_word(3'b101, 1'b0);
    send_word(3'b011, 1'b0);
    checks++; if (bm.pout !== 3'b101 || bm.pout_valid !== 1'b1) begin
      errors++; $display("FAIL bp_held got=%b v=%b exp=101 v=1", bm.pout, bm.pout_valid);
    end
    checks++; if (bm.sin_ready !== 1'b0 || bm.bit_cnt !== 3'(NB)) begin
      errors++; $display("FAIL bp_full got=rdy%b cnt%0d exp=rdy0 cnt%0d", bm.sin_ready, bm.bit_cnt, NB);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bm.sin_ready !== 1'b0 || bm.bit_cnt !== 3'(NB) || bm.pout !== 3'b101) begin
      errors++; $display("FAIL bp_refused got=rdy%b cnt%0d pout%b exp=rdy0 cnt%0d pout101", bm.sin_ready, bm.bit_cnt, bm.pout, NB);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bm.pout !== 3'b011 || bm.pout_valid !== 1'b1 || bm.sin_ready !== 1'b1 || bm.bit_cnt !== 3'd0) begin
      errors++; $display("FAIL bp_release got=%b v=%b rdy=%b cnt=%0d exp=011 v=1 rdy=1 cnt=0", bm.pout, bm.pout_valid, bm.sin_ready, bm.bit_cnt);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bm.pout_valid !== 1'b0 || bm.pout !== 3'b011) begin
      errors++; $display("FAIL bp_drain got=%b v=%b exp=011 v=0", bm.pout, bm.pout_valid);
    end
  endtask

  task automatic test_gaps_clear();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bm.bit_cnt !== 3'd1) begin errors++; $display("FAIL gap_cnt1 got=%0d exp=1", bm.bit_cnt); end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bm.bit_cnt !== 3'd2 || bm.pout_valid !== 1'b0) begin
      errors++; $display("FAIL gap_cnt2 got=cnt%0d v%b exp=cnt2 v0", bm.bit_cnt, bm.pout_valid);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (bm.bit_cnt !== 3'd0 || bm.pout_valid !== 1'b0) begin
      errors++; $display("FAIL gap_clear got=cnt%0d v%b exp=cnt0 v0", bm.bit_cnt, bm.pout_valid);
    end
    send_word(3'b110, 1'b0);
    checks++; if (bm.pout !== 3'b110 || bm.pout_valid !== 1'b1) begin
      errors++; $display("FAIL gap_word got=%b v=%b exp=110 v=1", bm.pout, bm.pout_valid);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (bm.pout_valid !== 1'b0 || bm.pout !== 3'b000 || bm.bit_cnt !== 3'd0) begin
      errors++; $display("FAIL clear_valid got=%b v=%b cnt=%0d exp=000 v=0 cnt=0", bm.pout, bm.pout_valid, bm.bit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[4] = '{3'b000, 3'b111, 3'b010, 3'b101};
    int seen = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = W - 1; i >= 0; i--) begin
        cyc(1'b1, words[k][i], 1'b1, 1'b0);
        checks++; if (bm.sin_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", bm.sin_ready); end
        if (bm.pout_valid === 1'b1) seen++;
      end
      if (PAR != 0) begin
        cyc(1'b1, ^words[k], 1'b1, 1'b0);
        if (bm.pout_valid === 1'b1) seen++;
      end
      checks++; if (bm.pout_valid !== 1'b1 || bm.pout !== words[k]) begin
        errors++; $display("FAIL b2b_word%0d got=%b v=%b exp=%b v=1", k, bm.pout, bm.pout_valid, words[k]);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (seen !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", seen); end
  endtask

  task automatic test_parity();
`ifdef PARITY_CHECK_EN
    logic [3:0] streams[2] = '{4'b1010, 4'b1011};
    for (int k = 0; k < 2; k++) begin
      for (int i = 3; i >= 0; i--) cyc(1'b1, streams[k][i], 1'b1, 1'b0);
      checks++; if (bm.pout !== 3'b101 || bm.pout_valid !== 1'b1 || bm.pout_perr !== 1'(k)) begin
        errors++; $display("FAIL parity%0d got=%b v=%b perr=%b exp=101 v=1 perr=%0d", k, bm.pout, bm.pout_valid, bm.pout_perr, k);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] e_pout;
    bit e_perr;
    int e_cnt;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 2000; n++) begin
      e_pout = (pend_w.size() > 0) ? pend_w[0] : last_pout;
      e_perr = (pend_p.size() > 0) ? pend_p[0] : last_perr;
      e_cnt  = (pend_w.size() == 2) ? NB : bits.size();
      checks++; if (bm.pout_valid !== (pend_w.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", n, bm.pout_valid, pend_w.size() > 0);
      end
      checks++; if (bm.pout !== e_pout || bm.pout_perr !== e_perr) begin
        errors++; $display("FAIL rnd_pout cyc%0d got=%b/%b exp=%b/%b", n, bm.pout, bm.pout_perr, e_pout, e_perr);
      end
      checks++; if (bm.sin_ready !== (pend_w.size() < 2) || bm.bit_cnt !== 3'(e_cnt)) begin
        errors++; $display("FAIL rnd_ctrl cyc%0d got=rdy%b cnt%0d exp=rdy%b cnt%0d", n, bm.sin_ready, bm.bit_cnt, pend_w.size() < 2, e_cnt);
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    bm.sin = 1'b0; bm.sin_valid = 1'b0; bm.pout_ready = 1'b0; bm.clear = 1'b0;
    bl.sin = 1'b0; bl.sin_valid = 1'b0; bl.pout_ready = 1'b0; bl.clear = 1'b0;
    test_reset();
    test_basic();
    test_lsb_first();
    test_backpressure();
    test_gaps_clear();
    test_back_to_back();
    test_parity();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
